// File: rtl/chacha20_stream_ctrl.sv
// chacha20_stream_ctrl
// Sequences one single-block ChaCha20 core over a multi-block message.
// A session is opened by cfg_load, which latches key, nonce and the first
// block counter. Each input block is handed to the core with the current
// counter. The core result is returned on the output stream, and the counter
// is advanced after every non-final block.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_load/key/nonce/counter    session configuration strobe and values
//   in_valid/ready/data/last      input block stream
//   out_valid/ready/data/last     output block stream
//   core_start/busy/done          core handshake
//   core_key/nonce/counter/in_state, core_out_state   core data path
//   session_active/done, err, err_code, block_count   status
module chacha20_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [255:0] cfg_key,
  input  logic [95:0]  cfg_nonce,
  input  logic [31:0]  cfg_counter,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         out_last,
  output logic         core_start,
  input  logic         core_busy,
  input  logic         core_done,
  output logic [255:0] core_key,
  output logic [95:0]  core_nonce,
  output logic [31:0]  core_counter,
  output logic [511:0] core_in_state,
  input  logic [511:0] core_out_state,
  output logic         session_active,
  output logic         session_done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [31:0]  block_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // The wait counter starts at 0 on the first WAIT cycle, so the last
  // allowed sample of core_done is at count TIMEOUT_CYCLES-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]   state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [95:0]  nonce_q, nonce_d;
  logic [31:0]  ctr_q, ctr_d;
  logic [511:0] in_st_q, in_st_d;
  logic         last_q, last_d;
  logic [511:0] out_q, out_d;
  logic [15:0]  tmo_q, tmo_d;
  logic [31:0]  blk_q, blk_d;
  logic [1:0]   ecode_q, ecode_d;
  logic         sd_q, sd_d;

  // Sequencing relies on core_done and the timeout only; busy is advisory.
  logic         busy_unused;
  assign busy_unused = core_busy;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    in_st_d = in_st_q;
    last_d  = last_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    blk_d   = blk_q;
    ecode_d = ecode_q;
    sd_d    = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (cfg_load) begin
          key_d   = cfg_key;
          nonce_d = cfg_nonce;
          ctr_d   = cfg_counter;
          blk_d   = 32'd0;
          ecode_d = 2'd0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          in_st_d = in_data;
          last_d  = in_last;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout hitting in the same cycle
        if (core_done) begin
          out_d   = core_out_state;
          state_d = S_OUT;
        end else if (tmo_q == TMO_LAST) begin
          ecode_d = 2'd2;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          blk_d = blk_q + 32'd1;
          if (last_q) begin
            sd_d    = 1'b1;
            state_d = S_IDLE;
          end else if (ctr_q == 32'hFFFF_FFFF) begin
            // refuse to wrap the block counter back to 0
            ecode_d = 2'd1;
            state_d = S_ERR;
          end else begin
            ctr_d   = ctr_q + 32'd1;
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      in_st_q <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      tmo_q   <= '0;
      blk_q   <= '0;
      ecode_q <= '0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      in_st_q <= in_st_d;
      last_q  <= last_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      blk_q   <= blk_d;
      ecode_q <= ecode_d;
      sd_q    <= sd_d;
    end
  end

  assign in_ready       = (state_q == S_ACCEPT);
  assign core_start     = (state_q == S_START);
  assign out_valid      = (state_q == S_OUT);
  assign out_last       = (state_q == S_OUT) & last_q;
  assign out_data       = out_q;
  assign session_active = (state_q == S_ACCEPT) | (state_q == S_START) |
                          (state_q == S_WAIT)   | (state_q == S_OUT);
  assign session_done   = sd_q;
  assign err            = (state_q == S_ERR);
  assign err_code       = ecode_q;
  assign block_count    = blk_q;
  assign core_key       = key_q;
  assign core_nonce     = nonce_q;
  assign core_counter   = ctr_q;
  assign core_in_state  = in_st_q;

endmodule

// File: doc/chacha20_stream_ctrl.md
# chacha20_stream_ctrl

Sequencer that drives one `ChaCha20` core over a multi-block message. It latches the key, nonce and initial counter per session. It accepts 512-bit plaintext/ciphertext blocks over a valid/ready stream, pulses the core once per block with an auto-incremented block counter, and returns the XORed result on an output stream. It sits between the system data path and the single-block `ChaCha20` core, and adds RFC 8439 counter-exhaustion and core-hang protection.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `core_done` after `core_start`; range 1..65535.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_load` in 1: one-cycle strobe that latches `cfg_key`, `cfg_nonce` and `cfg_counter` and opens a session. Honoured only in IDLE or ERR.
- `cfg_key` in 256: session key.
- `cfg_nonce` in 96: session nonce.
- `cfg_counter` in 32: block counter of the first block.
- `in_valid` / `in_ready` in / out 1: input block handshake.
- `in_data` in 512: plaintext or ciphertext block.
- `in_last` in 1: marks the final block of the session.
- `out_valid` / `out_ready` out / in 1: output block handshake.
- `out_data` out 512: core result.
- `out_last` out 1: copy of the `in_last` that entered with this block.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_busy` in 1: core busy.
- `core_done` in 1: core done (pulse or level).
- `core_key` out 256, `core_nonce` out 96, `core_counter` out 32, `core_in_state` out 512: registered core inputs, stable from `core_start` until done.
- `core_out_state` in 512: core result.
- `session_active` out 1: a session is open.
- `session_done` out 1: one-cycle pulse when the last block's output handshake completes.
- `err` out 1: sticky error; cleared by `cfg_load` or `rst`.
- `err_code` out 2: 0 none, 1 counter exhausted, 2 core timeout.
- `block_count` out 32: blocks delivered in the current session; cleared on `cfg_load`.

## Operation
- States:
  - IDLE: `in_ready`=0.
    - `cfg_load` → ACCEPT.
  - ACCEPT: `in_ready`=1.
    - `in_valid & in_ready` → latch `in_data` into `core_in_state` and `in_last` into a last flag → START.
  - START: `core_start`=1 for exactly one cycle; timeout counter cleared → WAIT.
  - WAIT: timeout counter increments each cycle.
    - `core_done` → capture `core_out_state` into `out_data` → OUT.
    - Counter reaching `TIMEOUT_CYCLES` with no `core_done` → ERR, code 2.
  - OUT: `out_valid`=1; `out_data` and `out_last` held stable until `out_ready`.
    - On handshake: `block_count`+1.
    - If the last flag is set → pulse `session_done`, clear `session_active` → IDLE.
    - Else if `core_counter` == 32'hFFFF_FFFF → ERR, code 1.
    - Else `core_counter`+1 (32-bit) → ACCEPT.
  - ERR: `in_ready`=0, `out_valid`=0, `session_active`=0, `err`=1.
    - Only `cfg_load` exits → ACCEPT, clearing `err`/`err_code`.
- Counter exhaustion is detected before the wrap. The block with counter 0xFFFFFFFF is delivered normally; only a following block is refused. 0xFFFFFFFF is never incremented to 0 and used.
- `cfg_load` in ACCEPT, START, WAIT or OUT is ignored (no state or register change).
- `core_done` outside WAIT is ignored. A `core_done` asserted in the same cycle the timeout hits counts as success (done wins).
- `core_key`, `core_nonce` and `core_counter` change only on `cfg_load` or on the counter increment in OUT.

## Timing
- Reset (sync, `rst`=1 at an edge): state IDLE.
  - `in_ready`, `out_valid`, `out_last`, `core_start`, `session_active`, `session_done`, `err` = 0.
  - `err_code` = 0; `block_count` = 0.
  - `out_data`, `core_in_state`, `core_key`, `core_nonce`, `core_counter` = 0.
- `rst` mid-operation aborts immediately. Any later `core_done` from the in-flight core is ignored because the controller is in IDLE.
- `cfg_load` at edge N → `session_active`=1 and `in_ready`=1 from N+1.
- Input handshake at edge N → `core_start` high during cycle N+1 → WAIT from N+2.
- `core_done` sampled at edge M → `out_valid`=1 from M+1.
- Back-to-back throughput is one block per (core latency + 4) cycles; there is no overlap, so `in_ready` is low from START through OUT.
- `out_valid` must not drop without `out_ready`. `out_data` is stable while `out_valid & !out_ready`.
- `session_done` is high in the cycle after the final output handshake.

## Test plan
- RFC 8439 §2.4.2 vector, counter 1:
  - Stimulus: key 00..1f, nonce 000000000000004a00000000, two blocks with `in_last` on the second.
  - Response: `core_counter` is 1 then 2; `out_data` matches the RFC ciphertext; `out_last` only on block 2; `session_done` one pulse; `block_count`=2.
- Round trip:
  - Stimulus: encrypt 0x41424344-pattern blocks, then feed the ciphertext back in a fresh session with the same config.
  - Response: output equals the original plaintext.
- Output backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles.
  - Response: `out_valid` held; `out_data` constant; `in_ready`=0; no second `core_start`.
- Counter exhaustion:
  - Stimulus: `cfg_counter`=32'hFFFF_FFFE, three blocks with no `in_last`.
  - Response: blocks with counters FFFFFFFE and FFFFFFFF delivered; then `err`=1, `err_code`=1, `in_ready`=0.
  - Then: `cfg_load` clears the error and returns `in_ready`=1.
- Core timeout:
  - Stimulus: stub core that never asserts done, `TIMEOUT_CYCLES`=8.
  - Response: `err_code`=2 exactly 8 cycles after WAIT entry.
  - Then: a `core_done` arriving afterwards is ignored.
- Reset and illegal config:
  - Stimulus: `rst` asserted during WAIT, then `cfg_load` pulsed during OUT in a new session.
  - Response: all outputs at reset values the cycle after `rst`; the mid-session `cfg_load` leaves `core_key` and `core_counter` unchanged.
